serial_adder: RTL and testbench

Bit-serial unsigned adder with carry-in. It computes `{Co, Sum} = A + B + Ci` one bit per clock, LSB first, under a start/busy/done handshake. It is the addition counterpart to the team's combinational 4-bit borrow-chain subtractor, and it trades latency for a single 1-bit full-adder cell plus a carry flop. Default width matches the existing 4-bit arithmetic blocks.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: {Co, Sum} = A + B + Ci, one bit per clock, LSB first.
// Latency WIDTH cycles from the start edge; one result per WIDTH+1 cycles back-to-back.
// No queuing: start is taken only in IDLE or DONE, and is ignored while busy.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, A, B, Ci request and operands, sampled together when busy is low
//   busy            high while bits are being processed
//   done            one-cycle pulse when Sum/Co (and Ovf) carry a new result
//   Sum, Co         registered result, held until the next result lands
//   Ovf             signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             load, last;
    logic             s, c_nxt;

    // single full-adder cell on the operand LSBs
    assign s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // a start in the DONE cycle chains straight into the next add
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Co     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Ci;
            cnt   <= '0;
        end else if (busy) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {s, sum_sh[WIDTH-1:1]};
            carry  <= c_nxt;
            cnt    <= cnt + CW'(1);
            // the final bit is merged here so the result lands on the DONE edge
            if (last) begin
                Sum <= {s, sum_sh[WIDTH-1:1]};
                Co  <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB at this point
                Ovf <= carry ^ c_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=4): directed vectors, scoreboard queue of
// expected results, and a negedge monitor that checks every done pulse.
// Ovf is checked only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Ci = 1'b0;
    logic         busy, done;
    logic [W-1:0] Sum;
    logic         Co;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Co    (Co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_done  = 0;
    int   n_exp   = 0;
    exp_t q[$];
    exp_t prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (q.size() == 0) begin
                check("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", {28'd0, Sum}, {28'd0, e.sum});
                check("co", {31'd0, Co}, {31'd0, e.co});
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", {31'd0, Ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Called at posedge+1; the following posedge is the start edge.
    // inject pulses a second start with other operands during RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input exp_t e, input bit inject);
        A = a; B = b; Ci = ci; start = 1'b1;
        q.push_back(e);
        n_exp++;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= W; i++) begin
            if (inject && i == 1) begin
                start = 1'b1; A = 4'd9; B = 4'd9;
            end
            @(posedge clk); #1;
            if (inject && i == 1) start = 1'b0;
            if (i < W) begin
                check("busy_run", {31'd0, busy}, 32'd1);
                check("done_early", {31'd0, done}, 32'd0);
                if (i == 2) begin
                    check("sum_held", {28'd0, Sum}, {28'd0, prev.sum});
                    check("co_held", {31'd0, Co}, {31'd0, prev.co});
                end
            end else begin
                check("done_latency", {31'd0, done}, 32'd1);
                check("busy_fall", {31'd0, busy}, 32'd0);
            end
        end
        prev = e;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        prev = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {28'd0, Sum}, 32'd0);
        check("rst_co", {31'd0, Co}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, Ovf}, 32'd0);
`endif
        idle_cycle();

        // 5 + 3 = 8 (signed 5+3 overflows)
        run_op(4'b0101, 4'b0011, 1'b0, '{sum: 4'b1000, co: 1'b0, ovf: 1'b1}, 1'b0);
        idle_cycle();

        // 15 + 1 = 16, then back-to-back 1 + 1 + 1 = 3 started in DONE
        run_op(4'b1111, 4'b0001, 1'b0, '{sum: 4'b0000, co: 1'b1, ovf: 1'b0}, 1'b0);
        run_op(4'b0001, 4'b0001, 1'b1, '{sum: 4'b0011, co: 1'b0, ovf: 1'b0}, 1'b0);
        idle_cycle();

        // max + max + 1 = 31
        run_op(4'b1111, 4'b1111, 1'b1, '{sum: 4'b1111, co: 1'b1, ovf: 1'b0}, 1'b0);
        idle_cycle();

        // 2 + 3 with a start (9 + 9) pulsed mid-RUN that must be ignored
        run_op(4'd2, 4'd3, 1'b0, '{sum: 4'd5, co: 1'b0, ovf: 1'b0}, 1'b1);
        idle_cycle();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        idle_cycle();

        // 7 + 1 = 8, signed overflow
        run_op(4'b0111, 4'b0001, 1'b0, '{sum: 4'b1000, co: 1'b0, ovf: 1'b1}, 1'b0);
        idle_cycle();

        // reset at the edge that would process bit 2: no done, outputs cleared
        A = 4'd5; B = 4'd6; Ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {28'd0, Sum}, 32'd0);
        check("abort_co", {31'd0, Co}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", {31'd0, Ovf}, 32'd0);
`endif
        repeat (6) @(posedge clk);
        #1;
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        prev = '0;

        // -8 + -8: Sum 0, carry out, signed overflow
        run_op(4'b1000, 4'b1000, 1'b0, '{sum: 4'b0000, co: 1'b1, ovf: 1'b1}, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        check("done_count", n_done, n_exp);
        check("queue_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
